// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared pipeline types for the hazard/forwarding controller:
// forward-select encodings, the zero register and a scoreboard entry.
package cpu_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from MEM ALU result

  localparam logic [4:0] REG_ZERO = 5'd0;

  // One pipeline stage worth of destination bookkeeping
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } sb_entry_t;

  // A stage produces register r if it is real, writes, and r is not r0
  function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] r);
    return e.valid && e.regwrite && (e.rd == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Decode-side bundle between the pipeline and the hazard/forwarding controller.
interface hazard_fwd_ctrl_if #(
  parameter int WIDTH_CNT = 16
);
  logic                 id_valid;
  logic [4:0]           id_rs;
  logic [4:0]           id_rt;
  logic                 id_use_rs;
  logic                 id_use_rt;
  logic [4:0]           id_rd;
  logic                 id_regwrite;
  logic                 id_memread;
  logic                 ex_branch_taken;
  logic [1:0]           fwd_a_sel;
  logic [1:0]           fwd_b_sel;
  logic                 stall;
  logic                 flush_id;
  logic [WIDTH_CNT-1:0] stall_cnt;

  // Pipeline side: presents the ID instruction, consumes controls
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
           id_regwrite, id_memread, ex_branch_taken,
    input  fwd_a_sel, fwd_b_sel, stall, flush_id, stall_cnt
  );

  // Controller side
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
           id_regwrite, id_memread, ex_branch_taken,
    output fwd_a_sel, fwd_b_sel, stall, flush_id, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl_fwd_match.sv
// Per-operand forward selection: compares one source register against the
// EX and MEM scoreboard entries. EX is checked first because it is the
// youngest producer and will sit in MEM when the consumer reaches EX.
module fwd_match
  import cpu_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       use_i,
  input  sb_entry_t  ex_i,
  input  sb_entry_t  mem_i,
  output logic [1:0] sel_o
);

  // Load flags are not needed here; load-use is resolved by the stall
  logic unused_memread;
  assign unused_memread = ex_i.memread ^ mem_i.memread;

  // Priority select: EX producer -> MEM result, MEM producer -> WB result
  always_comb begin
    sel_o = FWD_REG;
    if (use_i) begin
      if (sb_hit(ex_i, src_i))       sel_o = FWD_MEM;
      else if (sb_hit(mem_i, src_i)) sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller beside ID. Keeps an EX/MEM/WB scoreboard
// of destinations, registers forward selects on ID->EX advance, and raises
// load-use stall / branch flush combinationally.
module hazard_fwd_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH_CNT = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_fwd_ctrl_if.slave hzd
);

  localparam int NUM_OPS = 2;  // operand A (rs), operand B (rt)

  sb_entry_t ex_q, mem_q, wb_q, ex_d;
  sb_entry_t id_ent;

  logic [NUM_OPS-1:0][4:0] src;
  logic [NUM_OPS-1:0]      use_src;
  logic [NUM_OPS-1:0][1:0] fwd_sel;
  logic [NUM_OPS-1:0][1:0] sel_q, sel_d;

  logic [WIDTH_CNT-1:0] stall_cnt_q, stall_cnt_d;
  logic                 ld_dep, stall, flush, advance;

  // WB entry completes the scoreboard; regfile write-before-read means it
  // never needs to forward
  logic unused_wb;
  assign unused_wb = ^wb_q;

  assign id_ent = '{valid:    hzd.id_valid,
                    rd:       hzd.id_rd,
                    regwrite: hzd.id_regwrite,
                    memread:  hzd.id_memread};

  assign src[0]     = hzd.id_rs;
  assign src[1]     = hzd.id_rt;
  assign use_src[0] = hzd.id_use_rs;
  assign use_src[1] = hzd.id_use_rt;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    fwd_match u_match (
      .src_i (src[g]),
      .use_i (use_src[g]),
      .ex_i  (ex_q),
      .mem_i (mem_q),
      .sel_o (fwd_sel[g])
    );
  end

  // Load in EX whose result the ID instruction needs next cycle
  assign ld_dep = ex_q.valid && ex_q.memread && ex_q.regwrite &&
                  (ex_q.rd != REG_ZERO) &&
                  ((hzd.id_use_rs && (ex_q.rd == hzd.id_rs)) ||
                   (hzd.id_use_rt && (ex_q.rd == hzd.id_rt)));

  // Flush beats stall; both are forced low while reset is asserted
  assign stall   = !rst && hzd.id_valid && ld_dep && !hzd.ex_branch_taken;
  assign flush   = !rst && hzd.ex_branch_taken;
  assign advance = !stall && !flush;

  // Next EX entry and selects: ID instruction on advance, bubble otherwise
  always_comb begin
    ex_d  = '0;
    sel_d = '0;
    if (advance) begin
      ex_d  = id_ent;
      sel_d = fwd_sel;
    end
  end

  // Saturating stall-cycle counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Scoreboard shift, select registers and counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      sel_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      wb_q        <= mem_q;
      mem_q       <= ex_q;
      ex_q        <= ex_d;
      sel_q       <= sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hzd.fwd_a_sel = sel_q[0];
  assign hzd.fwd_b_sel = sel_q[1];
  assign hzd.stall     = stall;
  assign hzd.flush_id  = flush;
  assign hzd.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl with a 4-bit stall counter.
module tb_hazard_fwd_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hazard_fwd_ctrl_if #(.WIDTH_CNT(4)) bus ();

  hazard_fwd_ctrl #(.WIDTH_CNT(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .hzd (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rd,
                        input logic rw, input logic mr);
    bus.id_valid    = v;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_use_rs   = urs;
    bus.id_use_rt   = urt;
    bus.id_rd       = rd;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
  endtask

  task automatic nop();
    id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.ex_branch_taken = 1'b0;
    nop();
    #3;
    chk("rst_a_sel", 32'(bus.fwd_a_sel), 32'd0);
    chk("rst_b_sel", 32'(bus.fwd_b_sel), 32'd0);
    chk("rst_cnt",   32'(bus.stall_cnt), 32'd0);
    chk("rst_stall", 32'(bus.stall),     32'd0);
    bus.ex_branch_taken = 1'b1;
    #1;
    chk("rst_flush", 32'(bus.flush_id), 32'd0);
    bus.ex_branch_taken = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back: add r3 ; reader rs=r3
    id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    id_set(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
    #1;
    chk("b2b_stall", 32'(bus.stall), 32'd0);
    step();
    chk("b2b_a_sel", 32'(bus.fwd_a_sel), 32'd2);
    chk("b2b_b_sel", 32'(bus.fwd_b_sel), 32'd0);
    drain();

    // One gap: writer r3 ; independent r7 ; reader rt=r3
    id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    step();
    id_set(1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
    step();
    chk("gap_b_sel", 32'(bus.fwd_b_sel), 32'd1);
    chk("gap_a_sel", 32'(bus.fwd_a_sel), 32'd0);
    drain();

    // Both EX and MEM write r5: youngest wins
    id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    id_set(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    step();
    chk("young_a_sel", 32'(bus.fwd_a_sel), 32'd2);
    drain();

    // Load-use: lw r4 ; add rs=r4
    id_set(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
    step();
    id_set(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    chk("lu_stall", 32'(bus.stall), 32'd1);
    step();
    chk("lu_stall_once", 32'(bus.stall),     32'd0);
    chk("lu_bubble_sel", 32'(bus.fwd_a_sel), 32'd0);
    chk("lu_cnt",        32'(bus.stall_cnt), 32'd1);
    step();
    chk("lu_a_sel", 32'(bus.fwd_a_sel), 32'd1);
    drain();

    // Register 0 never forwards or stalls
    id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    step();
    id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    step();
    chk("r0_a_sel", 32'(bus.fwd_a_sel), 32'd0);
    chk("r0_b_sel", 32'(bus.fwd_b_sel), 32'd0);
    id_set(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    #1;
    chk("r0_ld_stall", 32'(bus.stall), 32'd0);
    step();
    chk("r0_ld_a_sel", 32'(bus.fwd_a_sel), 32'd0);
    drain();

    // Taken branch with a load-use condition: flush wins, EX bubble
    id_set(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
    step();
    id_set(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    bus.ex_branch_taken = 1'b1;
    #1;
    chk("br_flush", 32'(bus.flush_id), 32'd1);
    chk("br_stall", 32'(bus.stall),    32'd0);
    step();
    bus.ex_branch_taken = 1'b0;
    nop();
    chk("br_a_sel", 32'(bus.fwd_a_sel), 32'd0);
    chk("br_b_sel", 32'(bus.fwd_b_sel), 32'd0);
    chk("br_cnt",   32'(bus.stall_cnt), 32'd1);
    drain();

    // Back-to-back loads stall independently
    id_set(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
    step();
    id_set(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    #1;
    chk("ll_stall1", 32'(bus.stall), 32'd1);
    step();
    chk("ll_stall1_end", 32'(bus.stall), 32'd0);
    step();
    chk("ll_a_sel1", 32'(bus.fwd_a_sel), 32'd1);
    id_set(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    chk("ll_stall2", 32'(bus.stall), 32'd1);
    step();
    chk("ll_stall2_end", 32'(bus.stall), 32'd0);
    step();
    chk("ll_a_sel2", 32'(bus.fwd_a_sel), 32'd1);
    chk("ll_cnt",    32'(bus.stall_cnt), 32'd3);
    drain();

    // Reset in the middle of a stall
    id_set(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
    step();
    id_set(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    chk("mr_pre_stall", 32'(bus.stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_stall", 32'(bus.stall),     32'd0);
    chk("mr_a_sel", 32'(bus.fwd_a_sel), 32'd0);
    chk("mr_b_sel", 32'(bus.fwd_b_sel), 32'd0);
    chk("mr_cnt",   32'(bus.stall_cnt), 32'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("mr_post_stall", 32'(bus.stall), 32'd0);
    drain();

    // Saturation: self-dependent load in ID stalls every other cycle
    id_set(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
    repeat (10) step();
    chk("sat_cnt5", 32'(bus.stall_cnt), 32'd5);
    repeat (20) step();
    chk("sat_cnt15", 32'(bus.stall_cnt), 32'd15);
    repeat (12) step();
    chk("sat_hold", 32'(bus.stall_cnt), 32'd15);
    nop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
